// File: rtl/ipf_result_drain.sv
// Ping-pong capture of IPF result vectors, streamed out LSB-first as OUT_W-bit
// beats over a valid/ready bus; drops (sticky overflow) when both buffers are full.
module ipf_result_drain #(
  parameter int RES_W = 9216,
  parameter int OUT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  input  logic [RES_W-1:0] result,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_last,
  output logic [7:0]       o_frame,
  output logic [1:0]       occupancy,
  output logic             overflow
);

  localparam int BEATS = RES_W / OUT_W;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [OUT_W-1:0] frame_buf [2][BEATS];
  logic             wr_sel;
  logic             rd_sel;
  logic [BW-1:0]    beat;

  logic             hs;
  logic             frame_done;
  logic             accept;
  logic             capture;
  logic             drop;
  logic [1:0]       occ_next;

  // A full pair may still accept when the frame being drained frees its buffer this edge.
  always_comb begin
    hs         = o_valid && o_ready;
    frame_done = hs && (beat == LAST_BEAT);
    accept     = (occupancy != 2'd2) || frame_done;
    capture    = res_valid && accept && !rst;
    drop       = res_valid && !accept && !rst;
    occ_next   = occupancy;
    case ({capture, frame_done})
      2'b10:   occ_next = occupancy + 2'd1;
      2'b01:   occ_next = occupancy - 2'd1;
      default: occ_next = occupancy;
    endcase
  end

  assign o_valid = (state == SEND);
  assign o_last  = o_valid && (beat == LAST_BEAT);
  assign o_data  = o_valid ? frame_buf[rd_sel][beat] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      beat      <= '0;
      occupancy <= 2'd0;
      o_frame   <= 8'd0;
      overflow  <= 1'b0;
    end else begin
      if (capture) begin
        wr_sel <= ~wr_sel;
      end
      if (hs) begin
        if (frame_done) begin
          beat    <= '0;
          rd_sel  <= ~rd_sel;
          o_frame <= o_frame + 8'd1;
        end else begin
          beat <= beat + 1'b1;
        end
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      occupancy <= occ_next;
      state     <= (occ_next != 2'd0) ? SEND : IDLE;
    end
  end

  // Frame storage carries no reset; it is only ever read behind a valid occupancy.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int b = 0; b < BEATS; b++) begin
        frame_buf[wr_sel][b] <= result[b*OUT_W +: OUT_W];
      end
    end
  end

endmodule

// File: tb/tb_ipf_result_drain.sv
// Directed bench for ipf_result_drain: expected beats are queued when a result
// is driven and popped by a monitor on every output handshake.
module tb_ipf_result_drain;

  localparam int RES_W = 9216;
  localparam int OUT_W = 64;
  localparam int BEATS = RES_W / OUT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             res_valid = 1'b0;
  logic [RES_W-1:0] result = '0;
  logic             o_ready = 1'b0;
  logic             o_valid;
  logic [OUT_W-1:0] o_data;
  logic             o_last;
  logic [7:0]       o_frame;
  logic [1:0]       occupancy;
  logic             overflow;

  ipf_result_drain #(.RES_W(RES_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .result(result),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
    .o_frame(o_frame), .occupancy(occupancy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic             last;
    logic [7:0]       fr;
  } beat_t;

  beat_t            sb[$];
  int               checks = 0;
  int               errors = 0;
  int               hs_count = 0;
  logic [7:0]       next_frame = 8'd0;
  logic             prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_d = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RES_W-1:0] make_result(input int mode);
    logic [RES_W-1:0] r;
    r = '0;
    if (mode == 0) begin
      for (int k = 0; k < RES_W / 9; k++) r[k*9 +: 9] = 9'(k % 512);
    end else begin
      for (int w = 0; w < RES_W / 32; w++) r[w*32 +: 32] = $urandom;
    end
    return r;
  endfunction

  function automatic void push_frame(input logic [RES_W-1:0] r);
    beat_t e;
    for (int b = 0; b < BEATS; b++) begin
      e.d    = r[b*OUT_W +: OUT_W];
      e.last = (b == BEATS - 1);
      e.fr   = next_frame;
      sb.push_back(e);
    end
    next_frame = next_frame + 8'd1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [RES_W-1:0] r);
    result    = r;
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    res_valid  = 1'b0;
    sb.delete();
    next_frame = 8'd0;
    hs_count   = 0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int max, input bit rnd);
    int n;
    n = 0;
    do begin
      step();
      o_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || o_valid) && n < max);
    chk("drain_done", 64'(sb.size() == 0 && !o_valid), 1);
  endtask

  // Scoreboard monitor: inputs are stable here and apply at the next rising edge.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (prev_stall) begin
        chk("stall_valid", o_valid, 1);
        chk("stall_data", o_data, prev_d);
      end
      if (!o_valid) begin
        chk("idle_data", o_data, 0);
        chk("idle_last", o_last, 0);
      end
      if (o_valid && o_ready) begin
        hs_count++;
        chk("sb_nonempty", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("beat_data", o_data, e.d);
          chk("beat_last", o_last, e.last);
          chk("beat_frame", o_frame, e.fr);
        end
      end
    end
    prev_stall = !rst && o_valid && !o_ready;
    prev_d     = o_data;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [RES_W-1:0] r0, r1, r2;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_last", o_last, 0);
    chk("rst_frame", o_frame, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_ovf", overflow, 0);

    // Single frame, lane k = k mod 512
    step();
    o_ready = 1'b1;
    r0 = make_result(0);
    push_frame(r0);
    pulse(r0);
    @(negedge clk);
    chk("lat_valid", o_valid, 1);
    chk("lat_beat0", o_data, r0[63:0]);
    chk("lat_frame", o_frame, 0);
    repeat (BEATS) @(posedge clk);
    @(negedge clk);
    chk("single_end_valid", o_valid, 0);
    chk("single_end_occ", occupancy, 0);
    chk("single_sb_empty", 64'(sb.size()), 0);
    chk("single_hs", hs_count, BEATS);

    // Back-to-back frames three cycles apart
    do_reset();
    o_ready = 1'b1;
    r0 = make_result(1);
    r1 = make_result(1);
    push_frame(r0);
    push_frame(r1);
    pulse(r0);
    step();
    step();
    pulse(r1);
    @(negedge clk);
    chk("b2b_occ2", occupancy, 2);
    repeat (BEATS - 3) @(posedge clk);
    @(negedge clk);
    chk("b2b_f1_valid", o_valid, 1);
    chk("b2b_f1_frame", o_frame, 1);
    chk("b2b_f1_occ", occupancy, 1);
    repeat (BEATS) @(posedge clk);
    @(negedge clk);
    chk("b2b_end_valid", o_valid, 0);
    chk("b2b_ovf", overflow, 0);
    chk("b2b_hs", hs_count, 2 * BEATS);

    // Random back-pressure
    do_reset();
    o_ready = 1'b0;
    r0 = make_result(1);
    push_frame(r0);
    pulse(r0);
    wait_drain(3000, 1'b1);
    chk("bp_hs", hs_count, BEATS);

    // Overflow: third result dropped while both buffers are held
    do_reset();
    o_ready = 1'b0;
    r0 = make_result(1);
    r1 = make_result(1);
    r2 = make_result(1);
    push_frame(r0);
    push_frame(r1);
    pulse(r0);
    pulse(r1);
    pulse(r2);
    @(negedge clk);
    chk("ovf_occ", occupancy, 2);
    chk("ovf_flag", overflow, 1);
    chk("ovf_frame", o_frame, 0);
    wait_drain(1000, 1'b0);
    chk("ovf_hs", hs_count, 2 * BEATS);
    chk("ovf_sticky", overflow, 1);

    // Third result lands on the same edge as frame 0's last handshake
    do_reset();
    o_ready = 1'b0;
    r0 = make_result(1);
    r1 = make_result(1);
    r2 = make_result(1);
    push_frame(r0);
    push_frame(r1);
    pulse(r0);
    pulse(r1);
    o_ready = 1'b1;
    repeat (BEATS - 1) step();
    push_frame(r2);
    pulse(r2);
    @(negedge clk);
    chk("sim_occ", occupancy, 2);
    chk("sim_ovf", overflow, 0);
    chk("sim_frame", o_frame, 1);
    wait_drain(1000, 1'b0);
    chk("sim_hs", hs_count, 3 * BEATS);
    chk("sim_ovf_end", overflow, 0);

    // Reset in the middle of a frame, with a result offered during reset
    do_reset();
    o_ready = 1'b1;
    r0 = make_result(1);
    push_frame(r0);
    pulse(r0);
    repeat (70) step();
    rst = 1'b1;
    sb.delete();
    next_frame = 8'd0;
    hs_count = 0;
    result = make_result(1);
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_frame", o_frame, 0);
    chk("mid_rst_ovf", overflow, 0);
    step();
    r1 = make_result(1);
    push_frame(r1);
    pulse(r1);
    @(negedge clk);
    chk("post_rst_beat0", o_data, r1[63:0]);
    chk("post_rst_frame", o_frame, 0);
    wait_drain(500, 1'b0);
    chk("post_rst_hs", hs_count, BEATS);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
